// File: rtl/cipher_serdes_bridge.sv
// Lane-serial <-> block-wide bridge for a block-cipher core. Input: blk_vld 1 cycle after last beat, in_rdy stalls only the
// final beat while the hold stage is occupied. Output: first beat 1 cycle after res handshake. Optional CIPHER_SERDES_RES_BUF_EN adds a result buffer.
module cipher_serdes_bridge #(
  parameter int BLOCK_W = 128,
  parameter int LANE_W  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANE_W-1:0]  din,
  input  logic [LANE_W-1:0]  kin,
  input  logic               din_en,
  output logic               in_rdy,
  output logic [BLOCK_W-1:0] blk,
  output logic [BLOCK_W-1:0] blk_key,
  output logic               blk_vld,
  input  logic               blk_rdy,
  input  logic [BLOCK_W-1:0] res,
  input  logic               res_vld,
  output logic               res_rdy,
  output logic [LANE_W-1:0]  dout,
  output logic               dout_vld,
  output logic               dout_last,
  input  logic               dout_rdy
);

  // BLOCK_W must exceed LANE_W: the input shift register keeps all but the final beat.
  localparam int BEATS = BLOCK_W / LANE_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = BLOCK_W - LANE_W;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_M1  = CW'(BEATS - 2);

  typedef enum logic {IDLE, SHIFT} ostate_t;

  logic [SW-1:0]      sreg_d;
  logic [SW-1:0]      sreg_k;
  logic [CW-1:0]      icnt;
  logic               beat_acc;
  logic               beat_last;

  ostate_t            state;
  ostate_t            state_nxt;
  logic [BLOCK_W-1:0] oreg;
  logic [CW-1:0]      ocnt;
  logic               last_q;
  logic               oload_res;
  logic               oload_buf;
  logic               oshift;
  logic               oend;
  logic               rbuf_wr;

  assign in_rdy    = !(blk_vld && icnt == LAST_CNT);
  assign beat_acc  = din_en && in_rdy;
  assign beat_last = beat_acc && (icnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_d  <= '0;
      sreg_k  <= '0;
      icnt    <= '0;
      blk     <= '0;
      blk_key <= '0;
      blk_vld <= 1'b0;
    end else begin
      if (beat_acc) begin
        sreg_d <= (sreg_d << LANE_W) | SW'(din);
        sreg_k <= (sreg_k << LANE_W) | SW'(kin);
        if (icnt == LAST_CNT) begin
          icnt    <= '0;
          blk     <= {sreg_d, din};
          blk_key <= {sreg_k, kin};
        end else begin
          icnt <= icnt + CW'(1);
        end
      end
      // in_rdy blocks beat_last while blk_vld is set, so load and take never coincide.
      if (beat_last)
        blk_vld <= 1'b1;
      else if (blk_vld && blk_rdy)
        blk_vld <= 1'b0;
    end
  end

`ifdef CIPHER_SERDES_RES_BUF_EN
  logic [BLOCK_W-1:0] rbuf_q;
  logic               rbuf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_q    <= '0;
      rbuf_full <= 1'b0;
    end else if (oload_buf) begin
      rbuf_full <= 1'b0;
    end else if (rbuf_wr) begin
      rbuf_q    <= res;
      rbuf_full <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_rdy   = 1'b0;
    oload_res = 1'b0;
    oload_buf = 1'b0;
    oshift    = 1'b0;
    rbuf_wr   = 1'b0;
    oend      = dout_rdy && (ocnt == LAST_CNT);
    case (state)
      IDLE: begin
        res_rdy = 1'b1;
        if (res_vld) begin
          oload_res = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        oshift = dout_rdy;
`ifdef CIPHER_SERDES_RES_BUF_EN
        res_rdy = !rbuf_full;
        // On the last beat a waiting result chains straight into oreg; an empty buffer is bypassed.
        if (oend) begin
          if (rbuf_full)
            oload_buf = 1'b1;
          else if (res_vld)
            oload_res = 1'b1;
          else
            state_nxt = IDLE;
        end else if (res_vld && !rbuf_full) begin
          rbuf_wr = 1'b1;
        end
`else
        if (oend)
          state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg   <= '0;
      ocnt   <= '0;
      last_q <= 1'b0;
    end else if (oload_res) begin
      oreg   <= res;
      ocnt   <= '0;
      last_q <= (BEATS == 1);
`ifdef CIPHER_SERDES_RES_BUF_EN
    end else if (oload_buf) begin
      oreg   <= rbuf_q;
      ocnt   <= '0;
      last_q <= (BEATS == 1);
`endif
    end else if (oshift) begin
      oreg   <= oreg << LANE_W;
      ocnt   <= ocnt + CW'(1);
      last_q <= (ocnt == LAST_M1);
    end
  end

  assign dout      = oreg[BLOCK_W-1 -: LANE_W];
  assign dout_vld  = (state == SHIFT);
  assign dout_last = last_q;

endmodule

// File: tb/tb_cipher_serdes_bridge.sv
// Directed bench for cipher_serdes_bridge at LANE_W=8, BLOCK_W=128; follows CIPHER_SERDES_RES_BUF_EN if defined.
module tb_cipher_serdes_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   din = '0;
  logic [7:0]   kin = '0;
  logic         din_en = 1'b0;
  logic         in_rdy;
  logic [127:0] blk;
  logic [127:0] blk_key;
  logic         blk_vld;
  logic         blk_rdy = 1'b0;
  logic [127:0] res = '0;
  logic         res_vld = 1'b0;
  logic         res_rdy;
  logic [7:0]   dout;
  logic         dout_vld;
  logic         dout_last;
  logic         dout_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] RES_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] RES_B = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] RES_C = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  cipher_serdes_bridge #(.BLOCK_W(128), .LANE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .kin(kin), .din_en(din_en), .in_rdy(in_rdy),
    .blk(blk), .blk_key(blk_key), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
    .res(res), .res_vld(res_vld), .res_rdy(res_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last), .dout_rdy(dout_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic [7:0] k);
    din = d;
    kin = k;
    din_en = 1'b1;
    for (int n = 0; n < 50 && !in_rdy; n++) tick();
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL beat_wait in_rdy got %b want 1", in_rdy);
    end
    tick();
    din_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_rdy, blk_vld, res_rdy, dout_vld, dout_last} !== 5'b10100 || blk !== '0 || blk_key !== '0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals in_rdy/blk_vld/res_rdy/dout_vld/dout_last got %b want 10100 blk %h key %h dout %h",
               {in_rdy, blk_vld, res_rdy, dout_vld, dout_last}, blk, blk_key, dout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_assemble();
    for (int i = 0; i < 15; i++) drive_beat(8'(i), 8'(8'hF0 + i));
    checks++;
    if (blk_vld !== 1'b0) begin errors++; $display("FAIL asm_early blk_vld got %b want 0", blk_vld); end
    drive_beat(8'h0F, 8'hFF);
    checks++;
    if (blk_vld !== 1'b1) begin errors++; $display("FAIL asm_vld blk_vld got %b want 1", blk_vld); end
    checks++;
    if (blk !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL asm_blk got %h", blk); end
    checks++;
    if (blk_key !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF) begin errors++; $display("FAIL asm_key got %h", blk_key); end
    blk_rdy = 1'b1;
    tick();
    blk_rdy = 1'b0;
    checks++;
    if (blk_vld !== 1'b0) begin errors++; $display("FAIL asm_take blk_vld got %b want 0", blk_vld); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 31; i++) drive_beat(8'(8'h20 + i), 8'(8'h40 + i));
    checks++;
    if (in_rdy !== 1'b0 || blk_vld !== 1'b1) begin
      errors++;
      $display("FAIL stall_rdy in_rdy %b blk_vld %b want 0 1", in_rdy, blk_vld);
    end
    din = 8'h3F;
    kin = 8'h5F;
    din_en = 1'b1;
    tick();
    checks++;
    if (in_rdy !== 1'b0 || blk !== 128'h202122232425262728292A2B2C2D2E2F || blk_key !== 128'h404142434445464748494A4B4C4D4E4F) begin
      errors++;
      $display("FAIL stall_hold in_rdy %b blk %h key %h", in_rdy, blk, blk_key);
    end
    blk_rdy = 1'b1;
    tick();
    blk_rdy = 1'b0;
    checks++;
    if (blk_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release blk_vld %b in_rdy %b want 0 1", blk_vld, in_rdy);
    end
    tick();
    din_en = 1'b0;
    checks++;
    if (blk_vld !== 1'b1 || blk !== 128'h303132333435363738393A3B3C3D3E3F || blk_key !== 128'h505152535455565758595A5B5C5D5E5F) begin
      errors++;
      $display("FAIL stall_blk2 blk_vld %b blk %h key %h", blk_vld, blk, blk_key);
    end
    blk_rdy = 1'b1;
    tick();
    blk_rdy = 1'b0;
  endtask

  task automatic test_serialise();
    logic [127:0] exp;
    exp = RES_A;
    checks++;
    if (res_rdy !== 1'b1) begin errors++; $display("FAIL ser_idle res_rdy got %b want 1", res_rdy); end
    res = RES_A;
    res_vld = 1'b1;
    dout_rdy = 1'b1;
    tick();
    res_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp[127:120] || dout_last !== (i == 15)) begin
        errors++;
        $display("FAIL ser_beat%0d vld %b dout %h last %b want 1 %h %b", i, dout_vld, dout, dout_last, exp[127:120], i == 15);
      end
      exp = exp << 8;
      tick();
    end
    checks++;
    if (dout_vld !== 1'b0) begin errors++; $display("FAIL ser_end dout_vld got %b want 0", dout_vld); end
  endtask

  task automatic test_stall_out();
    logic [127:0] exp;
    int got;
    exp = RES_C;
    got = 0;
    res = RES_C;
    res_vld = 1'b1;
    dout_rdy = 1'b0;
    tick();
    res_vld = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp[127:120] || dout_last !== (got == 15)) begin
        errors++;
        $display("FAIL stall_beat%0d vld %b dout %h last %b want 1 %h %b", got, dout_vld, dout, dout_last, exp[127:120], got == 15);
      end
      dout_rdy = (cyc % 2 == 1);
      if (dout_rdy) begin
        exp = exp << 8;
        got++;
      end
      tick();
    end
    dout_rdy = 1'b1;
    checks++;
    if (got != 16 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_done beats %0d vld %b want 16 0", got, dout_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] stream;
    int beats;
    int gaps;
    int rsel;
    logic hs;
    int exp_gaps;
    logic exp_rdy;
`ifdef CIPHER_SERDES_RES_BUF_EN
    exp_gaps = 0;
    exp_rdy = 1'b1;
`else
    exp_gaps = 1;
    exp_rdy = 1'b0;
`endif
    stream = {RES_A, RES_B};
    beats = 0;
    gaps = 0;
    rsel = 0;
    dout_rdy = 1'b1;
    res = RES_A;
    res_vld = 1'b1;
    for (int cyc = 0; cyc < 80 && beats < 32; cyc++) begin
      hs = res_vld && res_rdy;
      tick();
      if (hs) begin
        rsel++;
        if (rsel == 1) begin
          res = RES_B;
          checks++;
          if (res_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_res_rdy got %b want %b", res_rdy, exp_rdy); end
        end else begin
          res_vld = 1'b0;
        end
      end
      if (dout_vld) begin
        checks++;
        if (dout !== stream[255 - 8*beats -: 8] || dout_last !== (beats % 16 == 15)) begin
          errors++;
          $display("FAIL b2b_beat%0d dout %h last %b want %h %b", beats, dout, dout_last, stream[255 - 8*beats -: 8], beats % 16 == 15);
        end
        beats++;
      end else if (beats > 0) begin
        gaps++;
      end
    end
    res_vld = 1'b0;
    checks++;
    if (beats != 32 || gaps != exp_gaps) begin
      errors++;
      $display("FAIL b2b_gaps beats %0d gaps %0d want 32 %0d", beats, gaps, exp_gaps);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    blk_rdy = 1'b0;
    for (int i = 0; i < 16; i++) drive_beat(8'h55, 8'hAA);
    for (int i = 0; i < 7; i++) drive_beat(8'h11, 8'h22);
    res = RES_A;
    res_vld = 1'b1;
    dout_rdy = 1'b1;
    tick();
    res_vld = 1'b0;
    repeat (4) tick();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 8'h44 || blk_vld !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre dout_vld %b dout %h blk_vld %b want 1 44 1", dout_vld, dout, blk_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_rdy, blk_vld, res_rdy, dout_vld, dout_last} !== 5'b10100 || blk !== '0 || blk_key !== '0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset in_rdy/blk_vld/res_rdy/dout_vld/dout_last got %b want 10100 blk %h key %h dout %h",
               {in_rdy, blk_vld, res_rdy, dout_vld, dout_last}, blk, blk_key, dout);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) drive_beat(8'(8'h80 + i), 8'(8'h70 + i));
    checks++;
    if (blk_vld !== 1'b0) begin errors++; $display("FAIL fresh_early blk_vld got %b want 0", blk_vld); end
    drive_beat(8'h8F, 8'h7F);
    checks++;
    if (blk_vld !== 1'b1 || blk !== 128'h808182838485868788898A8B8C8D8E8F || blk_key !== 128'h707172737475767778797A7B7C7D7E7F) begin
      errors++;
      $display("FAIL fresh_blk blk_vld %b blk %h key %h", blk_vld, blk, blk_key);
    end
  endtask

  initial begin
    test_reset();
    test_assemble();
    test_hold_stall();
    test_serialise();
    test_stall_out();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
